muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width in bits, even, >= 8.
REQ-002 SHALL have parameter OP_WIDTH, default 3: operation code width, carrying RV32M funct3 encoding.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands and op presented.
REQ-006 SHALL have port in_ready, output, 1: unit accepts a request this cycle.
REQ-007 SHALL have port op, input, OP_WIDTH: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have ports src_a and src_b, input, DATA_WIDTH each: rs1 and rs2 operands.
REQ-009 SHALL have port flush, input, 1: aborts any in-flight operation.
REQ-010 SHALL have port out_valid, output, 1: result holds valid data.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port result, output, DATA_WIDTH: operation result.

Function
REQ-013 SHALL use states IDLE, CALC and DONE.
REQ-014 SHALL assert in_ready only in IDLE; a request is accepted on a clk edge where in_valid and in_ready are both high.
REQ-015 On accept, SHALL latch op and operand magnitudes plus result sign, clear a DATA_WIDTH-step counter and go to CALC.
REQ-016 In CALC, SHALL perform one step per cycle: a shift-add multiply step or a restoring-divide step.
REQ-017 SHALL leave CALC for DONE after exactly DATA_WIDTH steps, so out_valid rises DATA_WIDTH+1 cycles after the accept edge.
REQ-018 SHALL form the full 2*DATA_WIDTH-bit product and return the low half for MUL and the high half for MULH/MULHSU/MULHU.
REQ-019 Sign handling SHALL be: MULH signed×signed; MULHSU signed src_a × unsigned src_b; MULHU, DIVU and REMU unsigned.
REQ-020 Signed results SHALL be produced by two's-complement negation of the unsigned magnitude result; remainder sign SHALL follow the dividend.
REQ-021 Divide by zero SHALL bypass CALC and go straight to DONE (out_valid one cycle after accept), returning quotient all-ones and remainder src_a.
REQ-022 Signed overflow (src_a = most-negative, src_b = -1, DIV/REM) SHALL bypass CALC, returning quotient src_a and remainder 0.
REQ-023 In DONE, SHALL hold out_valid high and result stable until out_ready is high at a clk edge, then return to IDLE.
REQ-024 SHALL NOT accept a new request in the same cycle as a result handoff; in_ready rises the following cycle.
REQ-025 flush high at a clk edge SHALL force IDLE from any state, drop out_valid and discard the operation; flush takes priority over accept and handoff.
REQ-026 result SHALL be 0 whenever out_valid is low.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counter 0, out_valid 0, result 0 and in_ready 1 after release.
REQ-028 Reset asserted mid-CALC or in DONE SHALL discard the operation with no residual output.

Structure
REQ-029 Package muldiv_pkg SHALL hold the op encoding enum, the state enum and the DATA_WIDTH default constant.
REQ-030 A single module SHALL suffice; no sub-module is required, and the shared adder/subtractor SHALL be inline.

Verification
REQ-031 MUL 7 × -3 -> out_valid after 33 cycles, result 0xFFFFFFEB.
REQ-032 MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000.
REQ-033 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF.
REQ-034 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; each with out_valid one cycle after accept.
REQ-035 out_ready held low 5 cycles in DONE -> result stable and in_ready low throughout; handoff -> in_ready high next cycle.
REQ-036 flush at step 10 of a DIV, and rst_n pulsed low mid-CALC -> IDLE, out_valid 0, result 0; a following MUL 3 × 4 returns 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // RV32M funct3 encoding of the operation
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, with the sign applied at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_e        state_q, state_d;
  op_e           op_q;
  logic          neg_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  hi_q, lo_q, opb_q, result_q;

  logic          accept, handoff, last_step;

  // request decode
  op_e           op_in;
  logic          a_signed, b_signed, a_neg, b_neg, in_neg;
  logic          div_zero, div_ovf, bypass;
  logic [W-1:0]  mag_a, mag_b, bypass_result;

  // step datapath
  logic          q_is_div, as_sub;
  logic [W:0]    shifted;
  logic [W+1:0]  as_x, as_y, as_sum;
  logic [W-1:0]  hi_n, lo_n, quot_s, rem_s, fin;
  logic [2*W-1:0] prod, prod_s;

  assign last_step = (cnt_q == CW'(W - 1));

  // Decode the incoming request: signedness, magnitudes and the special divide cases.
  // NOTE: every signal written in an always_comb gets a value before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    op_in         = op_e'(op);
    a_signed      = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed      = op_in inside {OP_MULH, OP_DIV, OP_REM};
    a_neg         = a_signed & src_a[W-1];
    b_neg         = b_signed & src_b[W-1];
    mag_a         = a_neg ? -src_a : src_a;
    mag_b         = b_neg ? -src_b : src_b;
    // Remainder sign follows the dividend; everything else is the sign product.
    in_neg        = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero      = (op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && (src_b == '0);
    div_ovf       = (op_in inside {OP_DIV, OP_REM}) && (src_a == MOST_NEG) && (src_b == '1);
    bypass        = div_zero | div_ovf;
    bypass_result = '0;
    if (div_zero) begin
      bypass_result = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : src_a;
    end else if (div_ovf) begin
      bypass_result = (op_in == OP_DIV) ? src_a : '0;
    end
  end

  // One iteration step through the shared adder/subtractor, plus sign fix-up of the final value.
  always_comb begin
    q_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    shifted  = {hi_q, lo_q[W-1]};
    as_sub   = q_is_div;
    as_x     = q_is_div ? {1'b0, shifted} : {2'b00, hi_q};
    as_y     = (q_is_div || lo_q[0]) ? {2'b00, opb_q} : '0;
    as_sum   = as_x + (as_sub ? ~as_y : as_y) + {{(W+1){1'b0}}, as_sub};
    if (q_is_div) begin
      // A negative difference means the divisor did not fit: restore the shifted value.
      hi_n = as_sum[W+1] ? shifted[W-1:0] : as_sum[W-1:0];
      lo_n = {lo_q[W-2:0], ~as_sum[W+1]};
    end else begin
      hi_n = as_sum[W:1];
      lo_n = {as_sum[0], lo_q[W-1:1]};
    end
    // The high half of a signed product needs the full-width negation, not just -hi.
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -lo_n : lo_n;
    rem_s  = neg_q ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:                       fin = prod_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:              fin = quot_s;
      default:                      fin = rem_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; flush overrides accept and handoff.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    handoff   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = bypass ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handoff = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      accept  = 1'b0;
      handoff = 1'b0;
      state_d = IDLE;
    end
  end

  // Operand latch, iteration registers and result capture.
  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values; the datapath registers are reset too so no stale operand
  // survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      neg_q    <= in_neg;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= mag_a;
      opb_q    <= mag_b;
      result_q <= bypass ? bypass_result : '0;
    end else if (state_q == CALC) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CW'(1);
      if (last_step) result_q <= fin;
    end else if (handoff) begin
      result_q <= '0;
    end
  end

  assign result = out_valid ? result_q : '0;

endmodule
